ram_portb_reader: RTL and testbench
===================================

Name: ram_portb_reader

Overview:
- Read-only master for port B of the dual-port data RAM; port A stays owned by the processor.
- On a start pulse, reads LEN consecutive words from address BASE and presents each one on a valid/ready output stream, with a last flag on the final word.
- Lets downstream logic (display, UART, debug dump) observe memory the processor has written, without stalling the processor.

Parameters:
- ADDR_W, 11, RAM port B address width.
- DATA_W, 8, RAM port B data width.
- RD_LAT, 1, clock edges from address sampled by the RAM to q_b valid (1 = unregistered RAM output, 2 = registered output).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request; sampled only in IDLE.
- base  input  ADDR_W  first address; captured on accepted start.
- len  input  ADDR_W+1  number of words to read, 0..2^ADDR_W; captured on accepted start.
- address_b  output  ADDR_W  RAM port B address, registered.
- data_b  output  DATA_W  RAM port B write data; constant 0.
- wren_b  output  1  RAM port B write enable; constant 0.
- q_b  input  DATA_W  RAM port B read data.
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accepts the word.
- m_data  output  DATA_W  stream word.
- m_last  output  1  high with the final word of the burst.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (synchronous, active-high): state IDLE; address_b=0, m_valid=0, m_data=0, m_last=0, busy=0, done=0. data_b and wren_b are 0 at all times.
- States: IDLE, WAIT, SEND, FIN.
- IDLE: on start with len!=0, capture base/len, set address_b=base and remaining=len, then go to WAIT with wait counter = RD_LAT.
- IDLE, start with len==0: go directly to FIN. No stream beats are produced.
- WAIT: decrement the wait counter each cycle. When it reaches 0, register m_data<=q_b, set m_valid=1, set m_last=(remaining==1), and go to SEND.
- WAIT timing: with RD_LAT=1, m_valid first rises 2 edges after the start edge.
- SEND: m_valid, m_data and m_last are held stable until the edge where m_valid && m_ready.
- SEND handshake edge: m_valid<=0 and m_last<=0.
  - If m_last: go to FIN.
  - Otherwise: address_b<=address_b+1, remaining--, reload the wait counter, and return to WAIT.
- FIN: done=1 for exactly one cycle, busy=1, then return to IDLE. busy falls the cycle after done.
- Throughput: one word per RD_LAT+2 cycles when m_ready is held high. m_ready low inserts stall cycles with no change to outputs.
- Address arithmetic is modulo 2^ADDR_W; 0x7FF+1 wraps to 0x000. len=2048 reads the whole RAM once.
- start while busy is ignored; no queuing, and captured base/len are unaffected.
- start held high continuously re-triggers a new burst on each return to IDLE, i.e. the cycle after done.
- m_ready high while m_valid=0 has no effect.
- Reset mid-burst: immediate return to IDLE with the reset values above. No done pulse, and no further beats from the aborted burst.
- No combinational path from m_ready to any output. All outputs are registered.

Test Plan:
- Reset behaviour: reset held 2 cycles during a burst -> m_valid=0, busy=0, done=0, address_b=0 on the next edge; no further beats appear.
- Basic burst: RAM preloaded with [0x10]=0xA1, [0x11]=0xB2, [0x12]=0xC3; start base=0x10 len=3, m_ready=1 -> beats A1, B2, C3 with m_last only on C3; first m_valid 2 cycles after start; beats 3 cycles apart; done pulse 1 cycle after the C3 handshake.
- Backpressure: same burst with m_ready low for 5 cycles while B2 is valid -> m_data holds B2 and m_valid stays 1 throughout; no beat is lost or duplicated; the sequence is still A1, B2, C3.
- Wrap and zero length: base=0x7FE len=4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001 are read in order. Separately, len=0 -> no m_valid, done 1 cycle after start.
- Start while busy: second start with base=0x20 pulsed mid-burst -> ignored; only the original 3 beats appear. A start the cycle after done is accepted and reads from 0x20.
- Port A concurrency: processor writes 0x55 to [0x11] via port A before the reader issues address 0x11 -> the reader emits 0x55. wren_b stays 0 for the entire test.

Source files
------------

// File: rtl/ram_portb_reader.sv
// Read-only burst master for port B of the dual-port data RAM: streams LEN
// consecutive words starting at BASE onto a valid/ready output with a last flag.
module ram_portb_reader #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] data_b,
  output logic              wren_b,
  input  logic [DATA_W-1:0] q_b,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam int unsigned CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [LEN_W-1:0]  remaining, rem_nxt;
  logic [CNT_W-1:0]  wait_cnt, cnt_nxt;
  logic              valid_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              last_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  // Port B never writes; port A belongs to the processor.
  assign data_b = '0;
  assign wren_b = 1'b0;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      address_b <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      address_b <= addr_nxt;
      remaining <= rem_nxt;
      wait_cnt  <= cnt_nxt;
      m_valid   <= valid_nxt;
      m_data    <= data_nxt;
      m_last    <= last_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    addr_nxt  = address_b;
    rem_nxt   = remaining;
    cnt_nxt   = wait_cnt;
    valid_nxt = m_valid;
    data_nxt  = m_data;
    last_nxt  = m_last;
    busy_nxt  = busy;
    done_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          busy_nxt = 1'b1;
          if (len == '0) begin
            state_nxt = FIN;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT;
            addr_nxt  = base;
            rem_nxt   = len;
            cnt_nxt   = CNT_RELOAD;
          end
        end
      end

      // The counter covers the RAM read latency plus the capture edge.
      WAIT: begin
        if (wait_cnt == '0) begin
          state_nxt = SEND;
          data_nxt  = q_b;
          valid_nxt = 1'b1;
          last_nxt  = (remaining == LEN_W'(1));
        end else begin
          cnt_nxt = wait_cnt - CNT_W'(1);
        end
      end

      SEND: begin
        if (m_valid && m_ready) begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          if (m_last) begin
            state_nxt = FIN;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = WAIT;
            addr_nxt  = address_b + ADDR_W'(1);
            rem_nxt   = remaining - LEN_W'(1);
            cnt_nxt   = CNT_RELOAD;
          end
        end
      end

      FIN: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_portb_reader.sv
// Scoreboard bench for ram_portb_reader: directed and random bursts checked
// against a behavioural RAM image and stream timing model.
`timescale 1ns/1ps
module tb_ram_portb_reader;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned LEN_W  = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;

  typedef struct {
    logic [DATA_W-1:0] data;
    bit                last;
    bit                first;
    int                ref_cyc;
  } beat_t;

  logic              clk;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] address_b;
  logic [DATA_W-1:0] data_b;
  logic              wren_b;
  logic [DATA_W-1:0] q_b;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;

  ram_portb_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .len(len),
    .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM contents seen by port B, and the bench's own view of what they should be.
  logic [DATA_W-1:0] ram     [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  always @(posedge clk) q_b <= ram[address_b];

  int    checks = 0;
  int    failures = 0;
  beat_t exp_q[$];
  bit    done_at[int];

  bit ready_rand = 1'b0;
  bit ready_val  = 1'b1;

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = ready_rand ? ($urandom_range(3) != 0) : ready_val;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stream monitor: beat order, data, last flag, hold under stall, timing, done.
  int                last_hs = 0;
  int                ref_c;
  beat_t             b;
  logic              prev_valid = 1'b0;
  logic              prev_reset = 1'b1;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  logic              prev_last  = 1'b0;

  always @(negedge clk) begin
    check("wren_b", wren_b, 0);
    check("data_b", data_b, 0);
    check("done", done, done_at.exists(cyc));
    if (done) check("busy_with_done", busy, 1);
    if (!prev_reset && prev_stall) begin
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, prev_data);
      check("hold_last", m_last, prev_last);
    end
    if (m_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", m_valid, 0);
      end else begin
        ref_c = exp_q[0].first ? exp_q[0].ref_cyc : last_hs;
        check("valid_rise_cycle", cyc, ref_c + RD_LAT + 1);
      end
    end
    if (m_valid && m_ready && !reset) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", m_valid, 0);
      end else begin
        b = exp_q.pop_front();
        check("m_data", m_data, b.data);
        check("m_last", m_last, b.last);
        last_hs = cyc + 1;
        if (b.last) done_at[cyc + 1] = 1'b1;
      end
    end
    prev_valid = m_valid;
    prev_reset = reset;
    prev_stall = m_valid && !m_ready && !reset;
    prev_data  = m_data;
    prev_last  = m_last;
  end

  task automatic ram_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  task automatic push_burst(input logic [ADDR_W-1:0] bs, input int n, input int s);
    beat_t             e;
    logic [ADDR_W-1:0] a;
    if (n == 0) done_at[s] = 1'b1;
    for (int i = 0; i < n; i++) begin
      a         = ADDR_W'((int'(bs) + i) % DEPTH);
      e.data    = ref_mem[a];
      e.last    = (i == n - 1);
      e.first   = (i == 0);
      e.ref_cyc = s;
      exp_q.push_back(e);
    end
  endtask

  // Call just after a clock edge with the reader idle; returns after the start edge.
  task automatic do_start(input logic [ADDR_W-1:0] bs, input int n, output int s);
    start = 1'b1;
    base  = bs;
    len   = LEN_W'(n);
    @(posedge clk);
    #1;
    s     = cyc;
    start = 1'b0;
    base  = ADDR_W'($urandom);
    len   = LEN_W'($urandom);
    push_burst(bs, n, s);
  endtask

  task automatic wait_done(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL wait_done: no done within %0d cycles (cycle %0d)", limit, cyc);
    end
  endtask

  task automatic next_idle();
    @(posedge clk);
    #1;
  endtask

  int s;
  int d;
  int n;
  int k;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    base  = '0;
    len   = '0;
    for (int i = 0; i < DEPTH; i++) ram_write(ADDR_W'(i), DATA_W'($urandom));
    ram_write(11'h010, 8'hA1);
    ram_write(11'h011, 8'hB2);
    ram_write(11'h012, 8'hC3);
    ram_write(11'h7FE, 8'h5A);
    ram_write(11'h7FF, 8'h6B);
    ram_write(11'h000, 8'h7C);
    ram_write(11'h001, 8'h8D);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_address_b", address_b, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Basic burst with m_ready held high.
    next_idle();
    do_start(11'h010, 3, s);
    wait_done(50);

    // Backpressure while the second word is valid.
    next_idle();
    do_start(11'h010, 3, s);
    repeat (5) @(negedge clk);
    ready_val = 1'b0;
    repeat (3) @(negedge clk);
    check("bp_hold_data", m_data, 8'hB2);
    check("bp_hold_valid", m_valid, 1);
    repeat (2) @(negedge clk);
    ready_val = 1'b1;
    wait_done(50);

    // Address wrap and zero length.
    next_idle();
    do_start(11'h7FE, 4, s);
    wait_done(60);
    next_idle();
    do_start(11'h123, 0, s);
    wait_done(10);

    // Start while busy is dropped; start the cycle after done is taken.
    next_idle();
    do_start(11'h010, 3, s);
    @(posedge clk);
    #1;
    start = 1'b1;
    base  = 11'h020;
    len   = LEN_W'(3);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(50);
    next_idle();
    do_start(11'h020, 3, s);
    wait_done(50);

    // Port A write lands before the reader addresses that word.
    next_idle();
    ref_mem[11'h011] = 8'h55;
    do_start(11'h010, 3, s);
    ram[11'h011] = 8'h55;
    wait_done(50);

    // Start held high retriggers right after done.
    next_idle();
    start = 1'b1;
    base  = 11'h030;
    len   = LEN_W'(2);
    @(posedge clk);
    #1;
    s = cyc;
    push_burst(11'h030, 2, s);
    wait_done(50);
    d = cyc;
    push_burst(11'h030, 2, d + 2);
    @(posedge clk);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(50);

    // Reset in the middle of a burst.
    next_idle();
    do_start(11'h040, 5, s);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    done_at.delete();
    @(negedge clk);
    @(negedge clk);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_address_b", address_b, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_busy", busy, 0);

    // Random bursts with random backpressure, ignored starts and port A writes.
    ready_rand = 1'b1;
    for (int t = 0; t < 25; t++) begin
      for (int w = 0; w < 4; w++) ram_write(ADDR_W'($urandom), DATA_W'($urandom));
      next_idle();
      n = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(1, 9));
      do_start(ADDR_W'($urandom), n, s);
      if (n > 0 && $urandom_range(1) == 1) begin
        k = int'($urandom_range(1, 3));
        repeat (k - 1) begin
          @(posedge clk);
          #1;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      wait_done(40 * n + 40);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    ready_rand = 1'b0;

    // Whole RAM read once from a mid-range base.
    for (int i = 0; i < DEPTH; i++) ram_write(ADDR_W'(i), DATA_W'($urandom));
    next_idle();
    do_start(11'h155, DEPTH, s);
    wait_done(3 * DEPTH + 50);

    repeat (10) @(negedge clk);
    check("beats_outstanding", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
